tx_arbiter: RTL and testbench

TX_ARBITER -- requirements
Module: tx_arbiter

---
 rtl/tx_arbiter.sv | 159 +++++++++++++++
 tb/tb_tx_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_arbiter.sv
// tx_arbiter: two-requester byte-stream arbiter in front of a USB PHY transmitter.
// Optional feature macro TX_ARBITER_CRC16_EN appends USB CRC16 to requester 1 packets.
module tx_arbiter #(
    parameter int GAP_CYCLES = 16
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       req0_valid_i,
    input  logic [7:0] req0_data_i,
    input  logic       req0_last_i,
    output logic       req0_ready_o,
    input  logic       req1_valid_i,
    input  logic [7:0] req1_data_i,
    input  logic       req1_last_i,
    output logic       req1_ready_o,
    output logic       tx_valid_o,
    output logic [7:0] tx_data_o,
    input  logic       tx_ready_i,
    input  logic       tx_en_i,
    output logic       grant_o,
    output logic       busy_o,
    output logic [2:0] state_o
);
    localparam int CW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES - 1);

`ifdef TX_ARBITER_CRC16_EN
    typedef enum logic [2:0] {
        IDLE = 3'd0, XFER = 3'd1, DRAIN = 3'd2, GAP = 3'd3, CRC_LO = 3'd4, CRC_HI = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE = 3'd0, XFER = 3'd1, DRAIN = 3'd2, GAP = 3'd3
    } state_t;
`endif

    state_t        state;
    logic [CW-1:0] gap_cnt;
    logic          g_valid;
    logic [7:0]    g_data;
    logic          g_last;

`ifdef TX_ARBITER_CRC16_EN
    logic [15:0] crc_q;
    logic        first_q;

    // Reflected form of poly 0x8005: data enters LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        end
        return r;
    endfunction
`endif

    assign g_valid = grant_o ? req1_valid_i : req0_valid_i;
    assign g_data  = grant_o ? req1_data_i  : req0_data_i;
    assign g_last  = grant_o ? req1_last_i  : req0_last_i;
    assign state_o = state;

    // Handshake: a byte moves when tx_valid_o and tx_ready_i are both high in the
    // same cycle; the granted requester's ready mirrors that transfer, with no buffering.
    always_comb begin
        tx_valid_o   = 1'b0;
        tx_data_o    = 8'h00;
        req0_ready_o = 1'b0;
        req1_ready_o = 1'b0;
        case (state)
            XFER: begin
                if (g_valid) begin
                    tx_valid_o   = 1'b1;
                    tx_data_o    = g_data;
                    req0_ready_o = !grant_o && tx_ready_i;
                    req1_ready_o = grant_o && tx_ready_i;
                end
            end
`ifdef TX_ARBITER_CRC16_EN
            CRC_LO: begin
                tx_valid_o = 1'b1;
                tx_data_o  = ~crc_q[7:0];
            end
            CRC_HI: begin
                tx_valid_o = 1'b1;
                tx_data_o  = ~crc_q[15:8];
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state   <= IDLE;
            grant_o <= 1'b0;
            busy_o  <= 1'b0;
            gap_cnt <= '0;
`ifdef TX_ARBITER_CRC16_EN
            crc_q   <= 16'hFFFF;
            first_q <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
`ifdef TX_ARBITER_CRC16_EN
                    crc_q   <= 16'hFFFF;
                    first_q <= 1'b1;
`endif
                    if (req0_valid_i) begin
                        grant_o <= 1'b0;
                        busy_o  <= 1'b1;
                        state   <= XFER;
                    end else if (req1_valid_i) begin
                        grant_o <= 1'b1;
                        busy_o  <= 1'b1;
                        state   <= XFER;
                    end
                end
                XFER: begin
                    // A requester dropping valid mid-packet aborts it without CRC.
                    if (!g_valid) begin
                        state <= DRAIN;
                    end else if (tx_ready_i) begin
`ifdef TX_ARBITER_CRC16_EN
                        if (grant_o && !first_q) crc_q <= crc16_byte(crc_q, g_data);
                        first_q <= 1'b0;
                        if (g_last) state <= grant_o ? CRC_LO : DRAIN;
`else
                        if (g_last) state <= DRAIN;
`endif
                    end
                end
`ifdef TX_ARBITER_CRC16_EN
                CRC_LO: if (tx_ready_i) state <= CRC_HI;
                CRC_HI: if (tx_ready_i) state <= DRAIN;
`endif
                DRAIN: begin
                    if (!tx_en_i) begin
                        gap_cnt <= GAP_LOAD;
                        state   <= GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_tx_arbiter.sv
// tb_tx_arbiter: randomized packets from both requesters checked against a
// packet-level model of ordering, byte stream, ready pulses, gap length and CRC.
module tb_tx_arbiter;
    localparam int G      = 16;
    localparam int BUDGET = 3000;

    logic       clk = 1'b0;
    logic       rstn;
    logic       req0_valid, req0_last, req0_ready;
    logic [7:0] req0_data;
    logic       req1_valid, req1_last, req1_ready;
    logic [7:0] req1_data;
    logic       tx_valid, tx_ready, tx_en;
    logic [7:0] tx_data;
    logic       grant, busy;
    logic [2:0] dut_state;

    always #5 clk = ~clk;

    tx_arbiter #(.GAP_CYCLES(G)) dut (
        .clk_i(clk), .rstn_i(rstn),
        .req0_valid_i(req0_valid), .req0_data_i(req0_data), .req0_last_i(req0_last),
        .req0_ready_o(req0_ready),
        .req1_valid_i(req1_valid), .req1_data_i(req1_data), .req1_last_i(req1_last),
        .req1_ready_o(req1_ready),
        .tx_valid_o(tx_valid), .tx_data_o(tx_data), .tx_ready_i(tx_ready), .tx_en_i(tx_en),
        .grant_o(grant), .busy_o(busy), .state_o(dut_state)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Packet model: each requester owns a byte array, a length and how many
    // bytes it will offer before dropping valid (send < len means abort).
    logic [7:0] pkt0[16];
    logic [7:0] pkt1[16];
    int         len0, len1, send0, send1, idx0, idx1;
    int         owner_q[$];
    logic [7:0] exp_q[$];
    int         cur_owner;
    int         idle_cnt;
    logic       prev_busy;
    logic       tx_en_nxt;
    int         phase, hold, gap_cnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // USB CRC16 computed the textbook way: bit-reverse each byte, MSB-first
    // division by 0x8005, bit-reverse the remainder, complement.
    function automatic logic [15:0] usb_crc16_req1();
        logic [15:0] c;
        logic [15:0] o;
        logic [7:0]  r;
        c = 16'hFFFF;
        for (int i = 1; i < len1; i++) begin
            for (int b = 0; b < 8; b++) r[b] = pkt1[i][7-b];
            c = c ^ {r, 8'h00};
            for (int k = 0; k < 8; k++) c = c[15] ? ((c << 1) ^ 16'h8005) : (c << 1);
        end
        for (int b = 0; b < 16; b++) o[b] = c[15-b];
        return ~o;
    endfunction

    task automatic set_pkt(input int r, input int len, input int send);
        for (int i = 0; i < 16; i++) begin
            if (r == 0) pkt0[i] = 8'($urandom_range(0, 255));
            else        pkt1[i] = 8'($urandom_range(0, 255));
        end
        if (r == 0) begin len0 = len; send0 = send; end
        else        begin len1 = len; send1 = send; end
    endtask

    task automatic start_episode();
        logic [15:0] crc;
        owner_q.delete();
        exp_q.delete();
        idx0 = 0;
        idx1 = 0;
        idle_cnt = 0;
        if (send0 > 0) begin
            owner_q.push_back(0);
            for (int i = 0; i < send0; i++) exp_q.push_back(pkt0[i]);
        end
        if (send1 > 0) begin
            owner_q.push_back(1);
            for (int i = 0; i < send1; i++) exp_q.push_back(pkt1[i]);
`ifdef TX_ARBITER_CRC16_EN
            if (send1 == len1) begin
                crc = usb_crc16_req1();
                exp_q.push_back(crc[7:0]);
                exp_q.push_back(crc[15:8]);
            end
`endif
        end
    endtask

    task automatic drive();
        req0_valid = (idx0 < send0);
        req0_data  = req0_valid ? pkt0[idx0] : 8'h00;
        req0_last  = req0_valid && (idx0 == len0 - 1);
        req1_valid = (idx1 < send1);
        req1_data  = req1_valid ? pkt1[idx1] : 8'h00;
        req1_last  = req1_valid && (idx1 == len1 - 1);
        tx_ready   = 1'($urandom_range(0, 1));
        tx_en      = tx_en_nxt;
    endtask

    task automatic sample();
        logic exp_r0, exp_r1;
        if (tx_valid !== 1'b1) check_eq("tx_data_when_idle", 32'(tx_data), 32'h0);
        if (busy === 1'b1 && prev_busy === 1'b0) begin
            check_eq("grant_expected", 32'(owner_q.size() > 0), 32'd1);
            if (owner_q.size() > 0) begin
                cur_owner = owner_q.pop_front();
                check_eq("grant_owner", 32'(grant), 32'(cur_owner));
                check_eq("grant_latency", 32'(idle_cnt), 32'd1);
            end
            idle_cnt = 0;
        end
        if (busy !== 1'b1) idle_cnt++;
        exp_r0 = (busy === 1'b1) && (cur_owner == 0) && (idx0 < send0) && tx_ready;
        exp_r1 = (busy === 1'b1) && (cur_owner == 1) && (idx1 < send1) && tx_ready;
        check_eq("req0_ready", 32'(req0_ready), 32'(exp_r0));
        check_eq("req1_ready", 32'(req1_ready), 32'(exp_r1));
        if (tx_valid === 1'b1 && tx_ready) begin
            check_eq("tx_byte_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) check_eq("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
        end
        if (req0_ready === 1'b1) idx0++;
        if (req1_ready === 1'b1) idx1++;
        // PHY model: bus driven from first byte until a few cycles after the stream ends.
        case (phase)
            0: if (tx_valid === 1'b1) begin tx_en_nxt = 1'b1; phase = 1; end
            1: if (tx_valid !== 1'b1) begin hold = $urandom_range(1, 3); phase = 2; end
            2: begin
                hold--;
                if (hold == 0) begin tx_en_nxt = 1'b0; gap_cnt = 0; phase = 3; end
            end
            default: begin
                if (busy === 1'b1) gap_cnt++;
                else begin
                    // one DRAIN cycle that sees tx_en low, then G gap cycles
                    check_eq("gap_len", 32'(gap_cnt), 32'(G + 1));
                    phase = 0;
                end
            end
        endcase
        prev_busy = busy;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        drive();
        @(negedge clk);
        sample();
    endtask

    task automatic run_episode(input string name);
        int cyc;
        start_episode();
        cyc = 0;
        do begin
            cycle();
            cyc++;
        end while (cyc < BUDGET && !(owner_q.size() == 0 && idx0 >= send0 && idx1 >= send1 &&
                                     busy === 1'b0 && phase == 0));
        check_eq({name, "_completes"}, 32'(cyc < BUDGET), 32'd1);
        check_eq({name, "_all_bytes_sent"}, 32'(exp_q.size()), 32'd0);
        send0 = 0;
        send1 = 0;
    endtask

    task automatic check_reset_outputs(input string name);
        check_eq({name, "_tx_valid"}, 32'(tx_valid), 32'd0);
        check_eq({name, "_tx_data"}, 32'(tx_data), 32'd0);
        check_eq({name, "_req0_ready"}, 32'(req0_ready), 32'd0);
        check_eq({name, "_req1_ready"}, 32'(req1_ready), 32'd0);
        check_eq({name, "_grant"}, 32'(grant), 32'd0);
        check_eq({name, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic clear_bench_state();
        send0 = 0; send1 = 0; idx0 = 0; idx1 = 0; len0 = 0; len1 = 0;
        owner_q.delete();
        exp_q.delete();
        cur_owner = -1;
        idle_cnt = 0;
        prev_busy = 1'b0;
        tx_en_nxt = 1'b0;
        phase = 0;
        hold = 0;
        gap_cnt = 0;
    endtask

    initial begin
        int cyc, sel, l, s;
        rstn = 1'b0;
        clear_bench_state();
        drive();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) cycle();
        check_eq("idle_no_request_busy", 32'(busy), 32'd0);

        set_pkt(0, 3, 3);
        pkt0[0] = 8'h2D; pkt0[1] = 8'h00; pkt0[2] = 8'h10;
        run_episode("req0_setup_pkt");

        set_pkt(0, 2, 2);
        set_pkt(1, 3, 3);
        run_episode("same_cycle_contention");

        set_pkt(1, 1, 1);
        pkt1[0] = 8'hC3;
        run_episode("req1_zlp");

        set_pkt(1, 4, 2);
        run_episode("req1_abort");

        // Reset while requester 1 is presenting its second byte.
        set_pkt(1, 4, 4);
        start_episode();
        cyc = 0;
        while (idx1 < 1 && cyc < 100) begin
            cycle();
            cyc++;
        end
        check_eq("midpkt_reached_byte2", 32'(idx1), 32'd1);
        @(posedge clk);
        #1;
        drive();
        #2;
        rstn = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        clear_bench_state();
        drive();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        set_pkt(0, 3, 3);
        run_episode("post_reset_req0");

        for (int e = 0; e < 30; e++) begin
            sel = $urandom_range(1, 3);
            if (sel % 2 == 1) begin
                l = $urandom_range(1, 8);
                s = (l > 1 && $urandom_range(0, 3) == 0) ? $urandom_range(1, l - 1) : l;
                set_pkt(0, l, s);
            end
            if (sel >= 2) begin
                l = $urandom_range(1, 8);
                s = (l > 1 && $urandom_range(0, 3) == 0) ? $urandom_range(1, l - 1) : l;
                set_pkt(1, l, s);
            end
            run_episode("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
